mat_sobel: RTL and testbench

Consumer of the 3x3 matrix stream produced by the line-buffer window generator.
- Assembles a 3x3 pixel window from three row taps, one column per mat_en beat.
- Computes the Sobel gradient magnitude through a 2-stage pipeline.
- Emits one 8-bit edge pixel per input beat, plus a per-frame done pulse.
- Sits between the window generator and the frame writer / VDMA side of the image pipeline.

---
 rtl/mat_pkg.sv | 14 +
 rtl/mat_sobel_grad.sv | 48 ++++
 rtl/mat_sobel.sv | 178 +++++++++++++++++
 tb/tb_mat_sobel.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// mat_pkg: widths, the pixel full-scale constant and the signed gradient type
// shared by the 3x3 kernel blocks of the image pipeline.
package mat_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int CNT_W  = 11;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  // Signed gradient; a 3x3 kernel with weights 1-2-1 on 8-bit pixels spans +/-1020.
  typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/mat_sobel_grad.sv
// mat_sobel_grad: Sobel Gx/Gy of a 3x3 window, registered one edge after the
// window is presented. pRC: R = 1 top .. 3 bottom, C = 1 oldest .. 3 newest.
module mat_sobel_grad #(
  parameter int PIX_W = mat_pkg::PIX_W
) (
  input  logic               clk,
  input  logic [PIX_W-1:0]   p11,
  input  logic [PIX_W-1:0]   p12,
  input  logic [PIX_W-1:0]   p13,
  input  logic [PIX_W-1:0]   p21,
  input  logic [PIX_W-1:0]   p22,
  input  logic [PIX_W-1:0]   p23,
  input  logic [PIX_W-1:0]   p31,
  input  logic [PIX_W-1:0]   p32,
  input  logic [PIX_W-1:0]   p33,
  output mat_pkg::grad_t     gx_q,
  output mat_pkg::grad_t     gy_q
);
  import mat_pkg::*;

  grad_t e11, e12, e13, e21, e23, e31, e32, e33;
  grad_t gx_d, gy_d;

  // The centre pixel carries zero weight in both kernels.
  logic unused_centre;
  assign unused_centre = ^p22;

  // Weighted column and row differences in signed arithmetic
  always_comb begin
    e11  = grad_t'(p11);
    e12  = grad_t'(p12);
    e13  = grad_t'(p13);
    e21  = grad_t'(p21);
    e23  = grad_t'(p23);
    e31  = grad_t'(p31);
    e32  = grad_t'(p32);
    e33  = grad_t'(p33);
    gx_d = (e13 + (e23 <<< 1) + e33) - (e11 + (e21 <<< 1) + e31);
    gy_d = (e31 + (e32 <<< 1) + e33) - (e11 + (e12 <<< 1) + e13);
  end

  // Stage A register; data only, qualified by the valid bit kept in the parent
  always_ff @(posedge clk) begin
    gx_q <= gx_d;
    gy_q <= gy_d;
  end

endmodule

// File: rtl/mat_sobel.sv
// mat_sobel: assembles a 3x3 window from three row taps (one column per
// mat_en beat) and emits one Sobel edge pixel per beat, two edges later.
// Build macro MAT_SOBEL_THRESH_EN: binarise the saturated magnitude against
// threshold (255 / 0); without it edge_pix is the saturated magnitude.
module mat_sobel #(
  parameter int PIX_W = mat_pkg::PIX_W,
  parameter int CNT_W = mat_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   mat_r1,
  input  logic [PIX_W-1:0]   mat_r2,
  input  logic [PIX_W-1:0]   mat_r3,
  input  logic               mat_en,
  input  logic [CNT_W-1:0]   col_num,
  input  logic [CNT_W-1:0]   row_num,
  input  logic [PIX_W-1:0]   threshold,
  output logic [PIX_W-1:0]   edge_pix,
  output logic               edge_en,
  output logic               frame_done
);
  import mat_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  // Window columns: index 0 oldest, 2 newest
  logic [PIX_W-1:0] top_q [3];
  logic [PIX_W-1:0] top_d [3];
  logic [PIX_W-1:0] mid_q [3];
  logic [PIX_W-1:0] mid_d [3];
  logic [PIX_W-1:0] bot_q [3];
  logic [PIX_W-1:0] bot_d [3];

  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] col_lim_q, col_lim_d;
  logic [CNT_W-1:0] row_lim_q, row_lim_d;
  logic [CNT_W-1:0] col_lim, row_lim;
  logic             col_last, row_last;

  logic vld_p0_q, vld_p0_d, brd_p0_q, brd_p0_d, last_p0_q, last_p0_d;
  logic vld_p1_q, vld_p1_d, brd_p1_q, brd_p1_d, last_p1_q, last_p1_d;

  grad_t            gx_p1_q, gy_p1_q;
  logic [GRAD_W-1:0] mag_p1;
  logic [PIX_W-1:0] sat_p1, res_p1;

  logic [PIX_W-1:0] edge_pix_q, edge_pix_d;
  logic             edge_en_q, edge_en_d;
  logic             frame_done_q, frame_done_d;

  function automatic logic [GRAD_W-1:0] abs_grad(input grad_t g);
    logic [GRAD_W-1:0] u;
    u = g[GRAD_W-1] ? -g : g;
    return u;
  endfunction

  function automatic logic [PIX_W-1:0] sat_pix(input logic [GRAD_W-1:0] m);
    if (m > {{(GRAD_W-PIX_W){1'b0}}, PIX_MAX}) return PIX_MAX;
    return m[PIX_W-1:0];
  endfunction

`ifndef MAT_SOBEL_THRESH_EN
  logic unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  // Window shift, column/row counters and per-beat control tags
  always_comb begin
    top_d     = top_q;
    mid_d     = mid_q;
    bot_d     = bot_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    col_lim_d = col_lim_q;
    row_lim_d = row_lim_q;
    // Geometry is taken live at the start of a row / frame and held until the
    // matching wrap, so port changes mid-row cannot split a row.
    col_lim   = (col_cnt_q == '0) ? col_num : col_lim_q;
    row_lim   = (col_cnt_q == '0 && row_cnt_q == '0) ? row_num : row_lim_q;
    col_last  = (col_cnt_q == col_lim - CNT_ONE);
    row_last  = (row_cnt_q == row_lim - CNT_ONE);
    vld_p0_d  = mat_en;
    brd_p0_d  = (col_cnt_q < CNT_TWO);
    last_p0_d = 1'b0;
    if (mat_en) begin
      top_d     = '{top_q[1], top_q[2], mat_r3};
      mid_d     = '{mid_q[1], mid_q[2], mat_r2};
      bot_d     = '{bot_q[1], bot_q[2], mat_r1};
      col_lim_d = col_lim;
      row_lim_d = row_lim;
      last_p0_d = col_last && row_last;
      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + CNT_ONE;
      end else begin
        col_cnt_d = col_cnt_q + CNT_ONE;
      end
    end
  end

  // ---- stage A: gradients registered in the sub-module ----
  mat_sobel_grad #(.PIX_W(PIX_W)) u_grad (
    .clk  (clk),
    .p11  (top_q[0]), .p12 (top_q[1]), .p13 (top_q[2]),
    .p21  (mid_q[0]), .p22 (mid_q[1]), .p23 (mid_q[2]),
    .p31  (bot_q[0]), .p32 (bot_q[1]), .p33 (bot_q[2]),
    .gx_q (gx_p1_q),
    .gy_q (gy_p1_q)
  );

  // Control tags travel with the stage A gradients
  always_comb begin
    vld_p1_d  = vld_p0_q;
    brd_p1_d  = brd_p0_q;
    last_p1_d = last_p0_q;
  end

  // ---- stage B: magnitude, saturation, optional binarisation, border mask ----
  always_comb begin
    mag_p1 = abs_grad(gx_p1_q) + abs_grad(gy_p1_q);
    sat_p1 = sat_pix(mag_p1);
`ifdef MAT_SOBEL_THRESH_EN
    res_p1 = (sat_p1 >= threshold) ? PIX_MAX : '0;
`else
    res_p1 = sat_p1;
`endif
    edge_pix_d   = edge_pix_q;
    if (vld_p1_q) edge_pix_d = brd_p1_q ? '0 : res_p1;
    edge_en_d    = vld_p1_q;
    frame_done_d = vld_p1_q && last_p1_q;
  end

  // State registers; reset clears the window, counters, valids and output
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q        <= '{default: '0};
      mid_q        <= '{default: '0};
      bot_q        <= '{default: '0};
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      col_lim_q    <= '0;
      row_lim_q    <= '0;
      vld_p0_q     <= 1'b0;
      brd_p0_q     <= 1'b0;
      last_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      brd_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      edge_pix_q   <= '0;
      edge_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      col_lim_q    <= col_lim_d;
      row_lim_q    <= row_lim_d;
      vld_p0_q     <= vld_p0_d;
      brd_p0_q     <= brd_p0_d;
      last_p0_q    <= last_p0_d;
      vld_p1_q     <= vld_p1_d;
      brd_p1_q     <= brd_p1_d;
      last_p1_q    <= last_p1_d;
      edge_pix_q   <= edge_pix_d;
      edge_en_q    <= edge_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign edge_pix   = edge_pix_q;
  assign edge_en    = edge_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mat_sobel.sv
// tb_mat_sobel: drives tap columns frame by frame and compares every emitted
// edge pixel, frame_done flag and output edge against a row-array model.
module tb_mat_sobel;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mat_r1, mat_r2, mat_r3, threshold;
  logic        mat_en;
  logic [10:0] col_num, row_num;
  logic [7:0]  edge_pix;
  logic        edge_en, frame_done;

  mat_sobel dut (
    .clk(clk), .rst(rst), .mat_r1(mat_r1), .mat_r2(mat_r2), .mat_r3(mat_r3),
    .mat_en(mat_en), .col_num(col_num), .row_num(row_num), .threshold(threshold),
    .edge_pix(edge_pix), .edge_en(edge_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int thr = 0;

  int exp_pix_q[$], exp_done_q[$], exp_cyc_q[$];
  int cap_pix_q[$], cap_en_q[$], cap_done_q[$], cap_cyc_q[$];
  int row_t[64], row_m[64], row_b[64];

  // Record every output event together with the edge number it appeared on
  always @(negedge clk) begin
    if (edge_en || frame_done) begin
      cap_pix_q.push_back(int'(edge_pix));
      cap_en_q.push_back(int'(edge_en));
      cap_done_q.push_back(int'(frame_done));
      cap_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pixel for column c of the current row, straight from the kernel definition
  function automatic int ref_pix(input int c);
    int gx, gy, mag, sat;
    if (c < 2) return 0;
    gx  = (row_t[c] + 2*row_m[c] + row_b[c]) - (row_t[c-2] + 2*row_m[c-2] + row_b[c-2]);
    gy  = (row_b[c-2] + 2*row_b[c-1] + row_b[c]) - (row_t[c-2] + 2*row_t[c-1] + row_t[c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    sat = (mag > 255) ? 255 : mag;
`ifdef MAT_SOBEL_THRESH_EN
    return (sat >= thr) ? 255 : 0;
`else
    return sat;
`endif
  endfunction

  task automatic clear_q();
    exp_pix_q.delete(); exp_done_q.delete(); exp_cyc_q.delete();
    cap_pix_q.delete(); cap_en_q.delete(); cap_done_q.delete(); cap_cyc_q.delete();
  endtask

  // mode 0 uniform 100, 1 vertical step at col 4, 2 horizontal step (top 0, others lvl), 3 random
  // gapm 0 none, 1 alternate idle, 2 random idle; max_beats < 0 runs and drains the whole frame
  task automatic drive_frame(input int cols, input int rows, input int mode, input int lvl,
                             input int gapm, input int max_beats);
    int nb, t, m, b, n;
    nb = 0;
    @(negedge clk);
    col_num   = 11'(cols);
    row_num   = 11'(rows);
    threshold = 8'(thr);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (max_beats >= 0 && nb >= max_beats) break;
        case (mode)
          0: begin t = 100; m = 100; b = 100; end
          1: begin t = (c >= 4) ? 200 : 0; m = t; b = t; end
          2: begin t = 0; m = lvl; b = lvl; end
          default: begin t = $urandom_range(0, 255); m = $urandom_range(0, 255); b = $urandom_range(0, 255); end
        endcase
        row_t[c] = t; row_m[c] = m; row_b[c] = b;
        if (nb > 0) @(negedge clk);
        mat_r3 = 8'(t); mat_r2 = 8'(m); mat_r1 = 8'(b); mat_en = 1'b1;
        exp_pix_q.push_back(ref_pix(c));
        exp_done_q.push_back((r == rows-1 && c == cols-1) ? 1 : 0);
        exp_cyc_q.push_back(cyc + 3);
        nb++;
        n = (gapm == 1) ? 1 : (gapm == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
          @(negedge clk);
          mat_en = 1'b0;
          mat_r1 = 8'($urandom); mat_r2 = 8'($urandom); mat_r3 = 8'($urandom);
        end
      end
    end
    if (max_beats < 0) begin
      @(negedge clk);
      mat_en = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mat_en = 1'b1; mat_r1 = 8'd77; mat_r2 = 8'd9; mat_r3 = 8'd200;
    col_num = 11'd8; row_num = 11'd4; threshold = 8'd0;
    repeat (4) @(negedge clk);
    checks++; if (edge_en !== 1'b0) begin errors++; $display("FAIL reset edge_en: got %0b expected 0", edge_en); end
    checks++; if (edge_pix !== 8'd0) begin errors++; $display("FAIL reset edge_pix: got %0d expected 0", edge_pix); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %0b expected 0", frame_done); end
    rst = 1'b0; mat_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (edge_en !== 1'b0) begin errors++; $display("FAIL idle edge_en: got %0b expected 0", edge_en); end
  endtask

  task automatic test_uniform();
    clear_q(); thr = 0;
    drive_frame(8, 4, 0, 0, 0, -1);
    checks++; if (cap_pix_q.size() != 32) begin errors++; $display("FAIL uniform count: got %0d expected 32", cap_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL uniform beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_vstep();
    clear_q(); thr = 50;
    drive_frame(8, 2, 1, 0, 0, -1);
    checks++; if (cap_pix_q.size() != exp_pix_q.size()) begin errors++; $display("FAIL vstep count: got %0d expected %0d", cap_pix_q.size(), exp_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL vstep beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_hstep();
    clear_q(); thr = 100;
    drive_frame(8, 2, 2, 50, 0, -1);
    checks++; if (cap_pix_q.size() != exp_pix_q.size()) begin errors++; $display("FAIL hstep count: got %0d expected %0d", cap_pix_q.size(), exp_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL hstep beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q(); thr = 100;
    drive_frame(8, 2, 2, 50, 1, -1);
    checks++; if (cap_pix_q.size() != exp_pix_q.size()) begin errors++; $display("FAIL gaps count: got %0d expected %0d", cap_pix_q.size(), exp_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL gaps beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  // Magnitudes 200 and 60 against threshold 100, then threshold 0 on a flat frame
  task automatic test_thresh();
    clear_q(); thr = 100;
    drive_frame(6, 1, 2, 50, 0, -1);
    drive_frame(6, 1, 2, 15, 0, -1);
    thr = 0;
    drive_frame(5, 1, 0, 0, 0, -1);
    checks++; if (cap_pix_q.size() != exp_pix_q.size()) begin errors++; $display("FAIL thresh count: got %0d expected %0d", cap_pix_q.size(), exp_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL thresh beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  // Random geometry (including widths below 3), random data, random idle gaps
  task automatic test_random();
    clear_q();
    for (int f = 0; f < 10; f++) begin
      thr = $urandom_range(0, 255);
      drive_frame($urandom_range(1, 12), $urandom_range(1, 4), 3, 0, 2, -1);
    end
    checks++; if (cap_pix_q.size() != exp_pix_q.size()) begin errors++; $display("FAIL random count: got %0d expected %0d", cap_pix_q.size(), exp_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL random beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  // One-cycle reset while the column-5 beat of row 1 is presented
  task automatic test_mid_reset();
    int rst_edge;
    int kp[$], kd[$], kc[$];
    clear_q(); thr = 100;
    drive_frame(8, 4, 3, 0, 0, 13);
    @(negedge clk);
    rst = 1'b1; mat_en = 1'b1; mat_r1 = 8'd250; mat_r2 = 8'd3; mat_r3 = 8'd90;
    rst_edge = cyc + 1;
    @(negedge clk);
    rst = 1'b0; mat_en = 1'b0;
    checks++; if (edge_en !== 1'b0) begin errors++; $display("FAIL midrst edge_en: got %0b expected 0", edge_en); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst frame_done: got %0b expected 0", frame_done); end
    repeat (4) @(negedge clk);
    for (int i = 0; i < exp_pix_q.size(); i++) begin
      if (exp_cyc_q[i] < rst_edge) begin kp.push_back(exp_pix_q[i]); kd.push_back(exp_done_q[i]); kc.push_back(exp_cyc_q[i]); end
    end
    checks++; if (cap_pix_q.size() != kp.size()) begin errors++; $display("FAIL midrst count: got %0d expected %0d", cap_pix_q.size(), kp.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < kp.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== kp[i] || cap_done_q[i] !== kd[i] || cap_cyc_q[i] !== kc[i]) begin
        errors++; $display("FAIL midrst beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], kp[i], kd[i], kc[i]);
      end
    end
    // Resume: counting restarts at column 0 of row 0
    clear_q();
    drive_frame(8, 2, 3, 0, 0, -1);
    checks++; if (cap_pix_q.size() != exp_pix_q.size()) begin errors++; $display("FAIL resume count: got %0d expected %0d", cap_pix_q.size(), exp_pix_q.size()); end
    for (int i = 0; i < cap_pix_q.size() && i < exp_pix_q.size(); i++) begin
      checks++;
      if (cap_en_q[i] !== 1 || cap_pix_q[i] !== exp_pix_q[i] || cap_done_q[i] !== exp_done_q[i] || cap_cyc_q[i] !== exp_cyc_q[i]) begin
        errors++; $display("FAIL resume beat %0d: got en=%0d pix=%0d done=%0d edge=%0d expected en=1 pix=%0d done=%0d edge=%0d",
                           i, cap_en_q[i], cap_pix_q[i], cap_done_q[i], cap_cyc_q[i], exp_pix_q[i], exp_done_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mat_en = 1'b0; mat_r1 = '0; mat_r2 = '0; mat_r3 = '0;
    col_num = 11'd8; row_num = 11'd4; threshold = '0;
    test_reset();
    test_uniform();
    test_vstep();
    test_hstep();
    test_gaps();
    test_thresh();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
